bit_stream_serializer: RTL and testbench
========================================

Name: bit_stream_serializer

Overview:
- Parallel-to-serial stage that sits directly upstream of the serial sequence detectors (1010 Mealy family).
- Accepts WIDTH-bit words over a valid/ready handshake and buffers one word in a holding register.
- Shifts each word out one bit per clock with a bit-valid qualifier and an end-of-frame strobe.
- Optionally inserts idle cycles between frames so downstream detectors see defined frame boundaries.

Parameters:
WIDTH, 8, data word width in bits (legal range 2..32)
MSB_FIRST, 1, 1 = bit WIDTH-1 transmitted first; 0 = bit 0 first
FRAME_GAP, 0, idle cycles inserted after each frame's last bit (0..15)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
flush  input  1  synchronous abort: drops held word and any frame in progress
in_valid  input  1  upstream word valid
in_ready  output  1  holding register empty; word accepted when in_valid && in_ready
in_data  input  WIDTH  word to serialize
bit_out  output  1  serial data bit, drives the detector's serial input
bit_valid  output  1  bit_out carries a frame bit this cycle
frame_last  output  1  high with the last bit of each frame
busy  output  1  hold_full or state != IDLE

Behaviour:
- Reset (reset low, asynchronous) clears all of the following:
  - state = IDLE, hold_full = 0, shreg = 0, bitcnt = 0, gapcnt = 0.
  - Outputs: in_ready = 1, bit_out = 0, bit_valid = 0, frame_last = 0, busy = 0.
- Reset mid-frame aborts immediately. No partial bits are emitted after release.
- Holding register:
  - in_ready = ~hold_full, decoded directly from the register.
  - Accept on in_valid && in_ready: hold <= in_data, hold_full <= 1.
  - Accept and load cannot occur in the same cycle, because load requires hold_full = 1 and accept requires hold_full = 0.
- FSM states are IDLE, SHIFT and GAP.
- IDLE:
  - If hold_full: load shreg <= hold, bitcnt <= 0, hold_full <= 0, go to SHIFT.
  - Else stay in IDLE.
- SHIFT:
  - bit_valid = 1.
  - bit_out = shreg[WIDTH-1] if MSB_FIRST, else shreg[0].
  - Each clock, shift left (MSB_FIRST) or right; the vacated bit is 0. Then bitcnt++.
  - frame_last = 1 when bitcnt == WIDTH-1.
- After the last bit (bitcnt == WIDTH-1):
  - If FRAME_GAP > 0: go to GAP with gapcnt <= FRAME_GAP-1.
  - Else if hold_full: reload from hold and stay in SHIFT. The next frame's bit follows with no bubble.
  - Else go to IDLE.
- GAP:
  - bit_valid = 0, bit_out = 0.
  - gapcnt decrements each cycle.
  - When gapcnt == 0: if hold_full, load and go to SHIFT; else go to IDLE.
- Outside SHIFT: bit_out = 0, bit_valid = 0, frame_last = 0. All three are combinational from registered state.
- Latency: a word accepted at edge N produces its first bit_valid in the cycle after edge N+1. In IDLE this is two cycles from the accept edge.
- Throughput: with FRAME_GAP = 0 and continuous in_valid, bit_valid stays high indefinitely. The held word is refilled during the current frame because WIDTH >= 2.
- flush (synchronous, highest priority after reset):
  - Next edge: state = IDLE, hold_full = 0, bitcnt = 0, gapcnt = 0.
  - An in_valid handshake in the same cycle as flush is discarded; the word is not stored.
- Backpressure: while hold_full = 1, in_ready = 0. Upstream holds in_data stable and no word is lost or duplicated.
- bitcnt is 5 bits. It never exceeds WIDTH-1 and has no wrap-around beyond the frame.

Test Plan:
- WIDTH=8, MSB_FIRST=1, FRAME_GAP=0; accept 8'hA5 at edge N -> bit_valid in cycles N+2..N+9; bit_out = 1,0,1,0,0,1,0,1; frame_last only in cycle N+9; busy falls after it.
- Back-to-back 8'hAA then 8'h55 with in_valid held high -> 16 contiguous bit_valid cycles emitting 1010101001010101. Connected to the 1010 detector, this gives two non-overlapping detections in the first frame. in_ready is low while hold is full.
- FRAME_GAP=2, two words queued -> 8 bits, exactly 2 cycles with bit_valid = 0, then the next 8 bits; frame_last is asserted twice in total.
- MSB_FIRST=0, send 8'h0D -> bit_out = 1,0,1,1,0,0,0,0.
- Third word presented while hold is full and a frame is shifting -> in_ready = 0 until the hold register empties. The word is then accepted exactly once, and all three words appear in order.
- flush at the 4th bit of 8'hF0 with 8'h0F held -> next cycle bit_valid = 0, busy = 0, in_ready = 1, and no 8'h0F bits are emitted. Reset pulled low mid-frame -> same result asynchronously, with outputs at reset values before the next edge.

Source files
------------

// File: rtl/bit_stream_serializer.sv
// Parallel-to-serial stage with a one-word holding register, valid/ready intake,
// a bit-valid qualifier, an end-of-frame strobe and optional idle cycles between frames.
module bit_stream_serializer #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1,
   parameter int unsigned FRAME_GAP = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] in_data_i,
   output logic             bit_out_o,
   output logic             bit_valid_o,
   output logic             frame_last_o,
   output logic             busy_o
);

   localparam logic [4:0] LastIdx = 5'(WIDTH - 1);
   localparam logic [3:0] GapInit = (FRAME_GAP > 0) ? 4'(FRAME_GAP - 1) : 4'd0;

   typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   hold_q, hold_d;
   logic               hold_full_q, hold_full_d;
   logic [WIDTH-1:0]   shreg_q, shreg_d;
   logic [4:0]         bitcnt_q, bitcnt_d;
   logic [3:0]         gapcnt_q, gapcnt_d;
   logic               load;
   logic               last_bit;

   assign in_ready_o = ~hold_full_q;
   assign last_bit   = (bitcnt_q == LastIdx);

   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      shreg_d     = shreg_q;
      bitcnt_d    = bitcnt_q;
      gapcnt_d    = gapcnt_q;
      load        = 1'b0;

      if (in_valid_i && in_ready_o) begin
         hold_d      = in_data_i;
         hold_full_d = 1'b1;
      end

      case (state_q)
         StIdle: begin
            if (hold_full_q) load = 1'b1;
         end
         StShift: begin
            shreg_d  = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
            bitcnt_d = bitcnt_q + 5'd1;
            if (last_bit) begin
               bitcnt_d = '0;
               if (FRAME_GAP > 0) begin
                  state_d  = StGap;
                  gapcnt_d = GapInit;
               end else if (hold_full_q) begin
                  load = 1'b1;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         StGap: begin
            if (gapcnt_q == 4'd0) begin
               if (hold_full_q) load = 1'b1;
               else state_d = StIdle;
            end else begin
               gapcnt_d = gapcnt_q - 4'd1;
            end
         end
         default: state_d = StIdle;
      endcase

      // Load never coincides with accept: it needs a full hold, accept an empty one.
      if (load) begin
         shreg_d     = hold_q;
         bitcnt_d    = '0;
         hold_full_d = 1'b0;
         state_d     = StShift;
      end

      if (flush_i) begin
         state_d     = StIdle;
         hold_full_d = 1'b0;
         bitcnt_d    = '0;
         gapcnt_d    = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         shreg_q     <= '0;
         bitcnt_q    <= '0;
         gapcnt_q    <= '0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         shreg_q     <= shreg_d;
         bitcnt_q    <= bitcnt_d;
         gapcnt_q    <= gapcnt_d;
      end
   end

   always_comb begin
      bit_valid_o  = (state_q == StShift);
      bit_out_o    = bit_valid_o & (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);
      frame_last_o = bit_valid_o & last_bit;
      busy_o       = hold_full_q | (state_q != StIdle);
   end

endmodule

// File: tb/tb_bit_stream_serializer.sv
// Three serializer configurations driven with random handshakes and flushes, checked
// against a frame-scheduling model that predicts every output per cycle.
module tb_bit_stream_serializer;

   localparam int NI  = 3;
   localparam int LEN = 2048;
   localparam int CW [NI] = '{8, 8, 2};
   localparam bit CM [NI] = '{1'b1, 1'b0, 1'b0};
   localparam int CG [NI] = '{0, 2, 15};

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       flush     [NI];
   logic       in_valid  [NI];
   logic       in_ready  [NI];
   logic [7:0] in_data   [NI];
   logic       bit_out   [NI];
   logic       bit_valid [NI];
   logic       frame_last[NI];
   logic       busy      [NI];

   always #5 clk = ~clk;

   bit_stream_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .FRAME_GAP(0)) u_dut0 (
      .clk(clk), .reset(reset), .flush_i(flush[0]), .in_valid_i(in_valid[0]),
      .in_ready_o(in_ready[0]), .in_data_i(in_data[0]), .bit_out_o(bit_out[0]),
      .bit_valid_o(bit_valid[0]), .frame_last_o(frame_last[0]), .busy_o(busy[0]));

   bit_stream_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .FRAME_GAP(2)) u_dut1 (
      .clk(clk), .reset(reset), .flush_i(flush[1]), .in_valid_i(in_valid[1]),
      .in_ready_o(in_ready[1]), .in_data_i(in_data[1]), .bit_out_o(bit_out[1]),
      .bit_valid_o(bit_valid[1]), .frame_last_o(frame_last[1]), .busy_o(busy[1]));

   bit_stream_serializer #(.WIDTH(2), .MSB_FIRST(1'b0), .FRAME_GAP(15)) u_dut2 (
      .clk(clk), .reset(reset), .flush_i(flush[2]), .in_valid_i(in_valid[2]),
      .in_ready_o(in_ready[2]), .in_data_i(in_data[2][1:0]), .bit_out_o(bit_out[2]),
      .bit_valid_o(bit_valid[2]), .frame_last_o(frame_last[2]), .busy_o(busy[2]));

   // Expected outputs per cycle index (cycle c = interval after rising edge c).
   bit         ev    [NI][LEN];
   bit         eb    [NI][LEN];
   bit         el    [NI][LEN];
   bit         ebusy [NI][LEN];
   int         hold_until[NI];
   int         next_free [NI];
   bit         off       [NI];
   logic [7:0] word      [NI];
   int         didx      [NI];

   int cyc;
   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cyc, obs, exp_v);
      end
   endtask

   function automatic bit dir_word(input int i, input int k, output logic [7:0] w);
      w = 8'h00;
      if (i == 0) begin
         case (k)
            0: w = 8'hA5;
            1: w = 8'hAA;
            2: w = 8'h55;
            3: w = 8'hF0;
            4: w = 8'h0F;
            default: return 1'b0;
         endcase
         return 1'b1;
      end
      if (i == 1) begin
         case (k)
            0: w = 8'h0D;
            1: w = 8'hF0;
            2: w = 8'h0F;
            default: return 1'b0;
         endcase
         return 1'b1;
      end
      return 1'b0;
   endfunction

   // Word accepted at edge a starts at the later of a+1 and the end of the previous frame+gap.
   task automatic sched(input int i, input int a, input logic [7:0] w);
      int s;
      s = (a + 1 > next_free[i]) ? a + 1 : next_free[i];
      for (int j = 0; j < CW[i]; j++) begin
         ev[i][s+j] = 1'b1;
         eb[i][s+j] = CM[i] ? w[CW[i]-1-j] : w[j];
         el[i][s+j] = (j == CW[i] - 1);
      end
      for (int p = a; p < s + CW[i] + CG[i]; p++) ebusy[i][p] = 1'b1;
      hold_until[i] = s;
      next_free[i]  = s + CW[i] + CG[i];
   endtask

   task automatic clr(input int i, input int from);
      for (int p = from; p < LEN; p++) begin
         ev[i][p]    = 1'b0;
         eb[i][p]    = 1'b0;
         el[i][p]    = 1'b0;
         ebusy[i][p] = 1'b0;
      end
   endtask

   task automatic check_reset_vals(input string tag);
      for (int i = 0; i < NI; i++) begin
         check_eq($sformatf("%s%0d in_ready", tag, i), 32'(in_ready[i]), 32'd1);
         check_eq($sformatf("%s%0d bit_out", tag, i), 32'(bit_out[i]), 32'd0);
         check_eq($sformatf("%s%0d bit_valid", tag, i), 32'(bit_valid[i]), 32'd0);
         check_eq($sformatf("%s%0d frame_last", tag, i), 32'(frame_last[i]), 32'd0);
         check_eq($sformatf("%s%0d busy", tag, i), 32'(busy[i]), 32'd0);
      end
   endtask

   initial begin
      logic [7:0] w;
      logic [7:0] m;
      bit         rdy;
      cyc = 0;
      for (int i = 0; i < NI; i++) begin
         flush[i] = 1'b0; in_valid[i] = 1'b0; in_data[i] = 8'h00;
         hold_until[i] = 0; next_free[i] = 0; off[i] = 1'b0; didx[i] = 0;
         clr(i, 0);
      end
      repeat (2) @(posedge clk);
      #1 check_reset_vals("rst_init");
      @(negedge clk) reset = 1'b1;
      cyc = 0;

      for (int n = 0; n < 1200; n++) begin
         @(posedge clk);
         cyc++;
         #1;
         for (int i = 0; i < NI; i++) begin
            check_eq($sformatf("i%0d bit_valid", i), 32'(bit_valid[i]), 32'(ev[i][cyc]));
            check_eq($sformatf("i%0d bit_out", i), 32'(bit_out[i]), 32'(eb[i][cyc]));
            check_eq($sformatf("i%0d frame_last", i), 32'(frame_last[i]), 32'(el[i][cyc]));
            check_eq($sformatf("i%0d busy", i), 32'(busy[i]), 32'(ebusy[i][cyc]));
            check_eq($sformatf("i%0d in_ready", i), 32'(in_ready[i]),
                     32'(cyc >= hold_until[i]));
         end

         if (cyc == 900) begin
            #2 reset = 1'b0;
            #1 check_reset_vals("rst_mid");
            #1 reset = 1'b1;
            for (int i = 0; i < NI; i++) begin
               clr(i, cyc);
               hold_until[i] = 0;
               next_free[i]  = 0;
               off[i]        = 1'b0;
            end
         end

         for (int i = 0; i < NI; i++) begin
            m = 8'((32'd1 << CW[i]) - 1);
            if (!off[i] && (cyc < 80 || $urandom_range(0, 3) != 0)) begin
               off[i] = 1'b1;
               if (dir_word(i, didx[i], w)) didx[i]++;
               else w = 8'($urandom) & m;
               word[i] = w;
            end
            in_valid[i] = off[i];
            in_data[i]  = word[i];
            flush[i]    = (cyc >= 80) && ($urandom_range(0, 49) == 0);
            rdy = (cyc >= hold_until[i]);
            if (flush[i]) begin
               clr(i, cyc + 1);
               hold_until[i] = cyc + 1;
               next_free[i]  = cyc + 1;
            end else if (off[i] && rdy) begin
               sched(i, cyc + 1, word[i]);
               off[i] = 1'b0;
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
